// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci engine and its BCD converter.
//   FIB_N       : default binary result width
//   FIB_D       : default number of BCD digits for display
//   fib_state_e : three-state handshake FSM encoding (idle/op/done)
package fib_pkg;

  localparam int unsigned FIB_N = 20;
  localparam int unsigned FIB_D = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } fib_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction cell: a digit of 5..9 gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : current BCD digit
//   digit_o : corrected digit (4-bit wrap, no carry out)
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i > 4'd4) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : conversion request, sampled only while idle
//   bin       : N-bit binary value, captured when start is accepted
//   ready     : high while idle
//   done_tick : one-cycle pulse when conversion completes
//   bcd       : D packed digits, digit 0 in [3:0]
module fib_bin2bcd
  import fib_pkg::*;
#(
  parameter int unsigned N = FIB_N,
  parameter int unsigned D = FIB_D
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   bin,
  output logic           ready,
  output logic           done_tick,
  output logic [4*D-1:0] bcd
);

  localparam int unsigned CW = $clog2(N + 1);

  fib_state_e     state_q;
  logic [N-1:0]   sh_q;
  logic [4*D-1:0] dig_q;
  logic [4*D-1:0] dig_adj;
  logic [CW-1:0]  cnt_q;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[4*g +: 4]),
      .digit_o (dig_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_q    <= bin;
            dig_q   <= '0;
            cnt_q   <= CW'(N);
            state_q <= ST_OP;
          end
        end
        ST_OP: begin
          dig_q <= {dig_adj[4*D-2:0], sh_q[N-1]};
          sh_q  <= {sh_q[N-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          // Leave on the edge that takes the counter to zero.
          if (cnt_q == CW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done_tick = (state_q == ST_DONE);
  assign bcd       = dig_q;

endmodule

// File: tb/tb_fib_bin2bcd.sv
module tb_fib_bin2bcd;

  localparam int N = 20;
  localparam int D = 7;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   bin;
  logic           ready;
  logic           done_tick;
  logic [4*D-1:0] bcd;

  int checks   = 0;
  int failures = 0;

  fib_bin2bcd #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain division.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Pulse start for one accept edge; returns at the negedge after it.
  task automatic start_conv(input int unsigned v);
    @(negedge clk);
    bin   = N'(v);
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done_tick; n = number of edges since the accept edge.
  task automatic wait_done(input int bound, output bit found, output int n,
                           output logic [4*D-1:0] res);
    found = 0;
    n     = 0;
    res   = '0;
    while (n < bound && !found) begin
      if (done_tick) begin
        found = 1;
        res   = bcd;
      end else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0;
    #12;
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== '0) begin
      failures++;
      $display("FAIL reset_state got ready=%b done=%b bcd=%h exp 1 0 0", ready, done_tick, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic convert_check(input string name, input int unsigned v);
    bit found; int n; logic [4*D-1:0] res;
    start_conv(v);
    wait_done(60, found, n, res);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_timeout got no done_tick exp done after %0d edges", name, N);
      return;
    end
    checks++;
    if (n !== N) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, n, N);
    end
    checks++;
    if (res !== ref_bcd(v)) begin
      failures++;
      $display("FAIL %s_bcd got=%h exp=%h", name, res, ref_bcd(v));
    end
    @(negedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== ref_bcd(v)) begin
      failures++;
      $display("FAIL %s_after got ready=%b done=%b bcd=%h exp 1 0 %h",
               name, ready, done_tick, bcd, ref_bcd(v));
    end
  endtask

  task automatic test_zero();
    convert_check("zero", 0);
  endtask

  task automatic test_fixed();
    convert_check("fib20", 6765);
    convert_check("max", (1 << N) - 1);
  endtask

  task automatic test_ignore_start();
    int ticks; logic [4*D-1:0] res;
    ticks = 0; res = '0;
    start_conv(99);
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready got=%b exp=0", ready);
    end
    bin   = N'(5);
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_tick) begin
        ticks++;
        res = bcd;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (ticks !== 1) begin
      failures++;
      $display("FAIL ignore_ticks got=%0d exp=1", ticks);
    end
    checks++;
    if (res !== ref_bcd(99)) begin
      failures++;
      $display("FAIL ignore_bcd got=%h exp=%h", res, ref_bcd(99));
    end
  endtask

  task automatic test_reset_mid();
    int ticks;
    ticks = 0;
    start_conv(12345);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== '0) begin
      failures++;
      $display("FAIL midreset got ready=%b done=%b bcd=%h exp 1 0 0", ready, done_tick, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (done_tick) ticks++;
    end
    checks++;
    if (ticks !== 0) begin
      failures++;
      $display("FAIL midreset_ticks got=%0d exp=0", ticks);
    end
    convert_check("postreset", 12345);
  endtask

  task automatic test_back_to_back();
    int ticks; int prev; int rdy;
    ticks = 0; prev = 0; rdy = 0;
    @(negedge clk);
    bin   = N'(4181);
    start = 1'b1;
    for (int c = 0; c < 120 && ticks < 4; c++) begin
      @(negedge clk);
      #1;
      if (done_tick) begin
        checks++;
        if (bcd !== ref_bcd(4181)) begin
          failures++;
          $display("FAIL b2b_bcd got=%h exp=%h", bcd, ref_bcd(4181));
        end
        if (ticks > 0) begin
          checks++;
          if (c - prev !== N + 2) begin
            failures++;
            $display("FAIL b2b_period got=%0d exp=%0d", c - prev, N + 2);
          end
          checks++;
          if (rdy !== 1) begin
            failures++;
            $display("FAIL b2b_ready_cycles got=%0d exp=1", rdy);
          end
        end
        rdy  = 0;
        prev = c;
        ticks++;
      end else if (ready) begin
        rdy++;
      end
    end
    checks++;
    if (ticks !== 4) begin
      failures++;
      $display("FAIL b2b_ticks got=%0d exp=4", ticks);
    end
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
  endtask

  task automatic test_random();
    int unsigned v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(0, (1 << N) - 1);
      convert_check("random", v);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fixed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
